// File: rtl/d_bus_pkg.sv
// Shared encodings for the SRAM-like data/instruction bus adapters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package d_bus_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bus transfer size codes
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Strips the MIPS kseg0/kseg1 segment bits to reach the physical address
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/d_sram_like_adapter_sel_decode.sv
// Byte-lane select to bus transfer size and low address bits.
// Latency: combinational.
// Backpressure: none; unknown lane patterns fall back to a word access.
module sel_decode
    import d_bus_pkg::*;
(
    input  logic [3:0] sel,
    output logic [1:0] size,
    output logic [1:0] addr_lo
);

    // One-hot lanes are bytes, aligned pairs are halves, everything else is a word
    always_comb begin
        size    = SZ_WORD;
        addr_lo = 2'd0;
        case (sel)
            4'b0001: begin size = SZ_BYTE; addr_lo = 2'd0; end
            4'b0010: begin size = SZ_BYTE; addr_lo = 2'd1; end
            4'b0100: begin size = SZ_BYTE; addr_lo = 2'd2; end
            4'b1000: begin size = SZ_BYTE; addr_lo = 2'd3; end
            4'b0011: begin size = SZ_HALF; addr_lo = 2'd0; end
            4'b1100: begin size = SZ_HALF; addr_lo = 2'd2; end
            default: begin size = SZ_WORD; addr_lo = 2'd0; end
        endcase
    end

endmodule

// File: rtl/d_sram_like_adapter.sv
// CPU M-stage SRAM-style port to split req/addr_ok/data_ok bus; optional ADDR_XLATE_EN kseg mapping.
// Latency: 2 stall cycles on a zero-wait bus, +1 per addr_ok or data_ok wait cycle.
// Backpressure: stalls the pipeline until data_ok; holds result in DONE while cpu_hold is set.
module d_sram_like_adapter
    import d_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic              cpu_wen,
    input  logic [3:0]        cpu_sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic [1:0]        dec_size;
    logic [1:0]        dec_addr_lo;
    logic [ADDR_W-1:0] addr_base;
    logic [ADDR_W-1:0] addr_mapped;
    logic              addr_lo_unused;

    sel_decode u_sel_decode (
        .sel     (cpu_sel),
        .size    (dec_size),
        .addr_lo (dec_addr_lo)
    );

    // The CPU's own low address bits are superseded by the lane decode
    assign addr_lo_unused = ^cpu_addr[1:0];
    assign addr_base      = {cpu_addr[ADDR_W-1:2], dec_addr_lo};

    // Bus-side address, optionally folded from kseg0/kseg1 to physical
    always_comb begin
        addr_mapped = addr_base;
`ifdef ADDR_XLATE_EN
        if (cpu_addr[ADDR_W-1 -: 2] == 2'b10) begin
            addr_mapped = addr_base & ADDR_W'(KSEG_MASK);
        end
`else
        addr_mapped = addr_base;
`endif
    end

    // Stall only until the result exists; DONE releases the pipeline
    assign cpu_stall = cpu_en & (state != DONE);

    // Next-state logic; data_ok outside ADDR/DATA is a stale response and ignored
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_en) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        state_nxt = DONE;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end
            end
            DONE: begin
                if (!cpu_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are frozen at issue so they stay stable while addr_ok is pending
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= SZ_BYTE;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (state == IDLE && cpu_en) begin
            bus_req   <= 1'b1;
            bus_wr    <= cpu_wen;
            bus_size  <= dec_size;
            bus_addr  <= addr_mapped;
            bus_wdata <= cpu_wdata;
        end else if (state == ADDR && bus_addr_ok) begin
            bus_req   <= 1'b0;
        end
    end

    // Load result is captured once and held until the next completed read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_rdata <= '0;
        end else if (capture && !bus_wr) begin
            cpu_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_d_sram_like_adapter.sv
module tb_d_sram_like_adapter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_en;
    logic        cpu_wen;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    int          n_stall, n_req, n_unstable;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_wr, r_done;
    logic [31:0] xlate_exp;

    always #5 clk = ~clk;

    d_sram_like_adapter dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_sel     (cpu_sel),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one CPU access and a bus slave that accepts the address after aw
    // request cycles and returns data dw cycles later (dw=0: same cycle).
    // Returns in the first non-stalled cycle.
    task automatic access(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int aw, input int dw, input logic hold,
                          output int stalls, output int reqs, output int unstable,
                          output logic [31:0] baddr, output logic [31:0] bwdata,
                          output logic [1:0] bsize, output logic bwr, output logic done);
        int   rc;
        int   dc;
        logic in_data;
        rc = 0; dc = 0; in_data = 1'b0;
        stalls = 0; reqs = 0; unstable = 0; done = 1'b0;
        baddr = '0; bwdata = '0; bsize = '0; bwr = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            cpu_en = 1'b1; cpu_wen = wr; cpu_sel = sel; cpu_addr = addr;
            cpu_wdata = wdata; cpu_hold = hold;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0BAD_0BAD;
            if (bus_req && !in_data) begin
                if (rc == aw) begin
                    bus_addr_ok = 1'b1;
                    if (dw == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = rdata;
                    end else begin
                        in_data = 1'b1;
                    end
                end
                rc++;
            end else if (in_data) begin
                dc++;
                if (dc == dw) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = rdata;
                    in_data     = 1'b0;
                end
            end
            #1;
            if (bus_req) begin
                if (reqs == 0) begin
                    baddr = bus_addr; bsize = bus_size; bwr = bus_wr; bwdata = bus_wdata;
                end else if ({bus_addr, bus_size, bus_wr, bus_wdata} != {baddr, bsize, bwr, bwdata}) begin
                    unstable++;
                end
                reqs++;
            end
            if (cpu_stall) begin
                stalls++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
    endtask

    // Pipeline advances past the completed access
    task automatic release_cycle;
        step();
        cpu_en = 1'b0; cpu_wen = 1'b0; cpu_hold = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0; cpu_en = 1'b1; cpu_wen = 1'b0; cpu_sel = 4'hF;
        cpu_addr = '0; cpu_wdata = '0; cpu_hold = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        #3;
        check("rst_stall_en1", 32'(cpu_stall), 32'd1);
        cpu_en = 1'b0;
        #1;
        check("rst_stall_en0", 32'(cpu_stall), 32'd0);
        check("rst_req",   32'(bus_req), 32'd0);
        check("rst_wr",    32'(bus_wr), 32'd0);
        check("rst_size",  32'(bus_size), 32'd0);
        check("rst_addr",  bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        step(); step();
        resetn = 1'b1;
        step();

        // Zero-wait word load
        access(1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("zw_done",   32'(r_done), 32'd1);
        check("zw_stall",  32'(n_stall), 32'd2);
        check("zw_req",    32'(n_req), 32'd1);
        check("zw_size",   32'(r_size), 32'd2);
        check("zw_wr",     32'(r_wr), 32'd0);
        check("zw_addr",   r_addr, 32'h0000_1000);
        check("zw_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        check("zw_state",  32'(dut.state), 32'd3);
        release_cycle();
        check("zw_idle",   32'(dut.state), 32'd0);
        check("zw_rhold",  cpu_rdata, 32'hDEAD_BEEF);

        // Byte store with addr_ok and data_ok waits
        access(1'b1, 4'b0100, 32'h0000_2003, 32'h00AB_0000, 32'h0BAD_F00D, 3, 2, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("st_done",   32'(r_done), 32'd1);
        check("st_stall",  32'(n_stall), 32'd7);
        check("st_req",    32'(n_req), 32'd4);
        check("st_stable", 32'(n_unstable), 32'd0);
        check("st_addr",   r_addr, 32'h0000_2002);
        check("st_size",   32'(r_size), 32'd0);
        check("st_wr",     32'(r_wr), 32'd1);
        check("st_wdata",  r_wdata, 32'h00AB_0000);
        check("st_rkeep",  cpu_rdata, 32'hDEAD_BEEF);
        release_cycle();

        // Half load completing under an external hold
        access(1'b0, 4'b0011, 32'h0000_4002, 32'h0, 32'h0000_1234, 0, 1, 1'b1,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("hd_done",   32'(r_done), 32'd1);
        check("hd_stall",  32'(n_stall), 32'd3);
        check("hd_size",   32'(r_size), 32'd1);
        check("hd_addr",   r_addr, 32'h0000_4000);
        check("hd_rdata",  cpu_rdata, 32'h0000_1234);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hd_state_done", 32'(dut.state), 32'd3);
            check("hd_no_stall",   32'(cpu_stall), 32'd0);
            check("hd_no_req",     32'(bus_req), 32'd0);
            check("hd_rstable",    cpu_rdata, 32'h0000_1234);
        end
        cpu_hold = 1'b0; cpu_en = 1'b0;
        step();
        check("hd_idle",   32'(dut.state), 32'd0);
        check("hd_req0",   32'(bus_req), 32'd0);

        // Illegal lane pattern falls back to a word access
        access(1'b0, 4'b0101, 32'h0000_3001, 32'h0, 32'h1111_2222, 0, 0, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("il_done",   32'(r_done), 32'd1);
        check("il_stall",  32'(n_stall), 32'd2);
        check("il_size",   32'(r_size), 32'd2);
        check("il_addr",   r_addr, 32'h0000_3000);
        check("il_rdata",  cpu_rdata, 32'h1111_2222);
        release_cycle();

        // Upper half store with one addr_ok wait
        access(1'b1, 4'b1100, 32'h0000_5001, 32'hABCD_0000, 32'h0, 1, 0, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("hh_stall",  32'(n_stall), 32'd3);
        check("hh_req",    32'(n_req), 32'd2);
        check("hh_size",   32'(r_size), 32'd1);
        check("hh_addr",   r_addr, 32'h0000_5002);
        release_cycle();

        // Segment mapping
`ifdef ADDR_XLATE_EN
        xlate_exp = 32'h1FC0_0004;
`else
        xlate_exp = 32'hBFC0_0004;
`endif
        access(1'b0, 4'b1111, 32'hBFC0_0004, 32'h0, 32'h3C08_0001, 0, 0, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("xl_addr",   r_addr, xlate_exp);
        release_cycle();

        // Flush: cpu_en drops while the request is outstanding
        cpu_en = 1'b1; cpu_wen = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h0000_6000;
        step();
        cpu_en = 1'b0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
        #1;
        check("fl_stall",  32'(cpu_stall), 32'd0);
        check("fl_req",    32'(bus_req), 32'd1);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        check("fl_done",   32'(dut.state), 32'd3);
        check("fl_rdata",  cpu_rdata, 32'h5555_AAAA);
        step();
        check("fl_idle",   32'(dut.state), 32'd0);

        // Asynchronous reset while waiting for data
        cpu_en = 1'b1; cpu_wen = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h0000_7000;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        #1;
        check("ar_in_data", 32'(dut.state), 32'd2);
        resetn = 1'b0;
        #1;
        check("ar_state",  32'(dut.state), 32'd0);
        check("ar_req",    32'(bus_req), 32'd0);
        check("ar_addr",   bus_addr, 32'd0);
        check("ar_rdata",  cpu_rdata, 32'd0);
        cpu_en = 1'b0;
        step();
        resetn = 1'b1;
        bus_data_ok = 1'b1; bus_rdata = 32'hFEED_FACE;
        step();
        bus_data_ok = 1'b0;
        #1;
        check("ar_stale_state", 32'(dut.state), 32'd0);
        check("ar_stale_rdata", cpu_rdata, 32'd0);
        access(1'b0, 4'b1111, 32'h0000_8000, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0,
               n_stall, n_req, n_unstable, r_addr, r_wdata, r_size, r_wr, r_done);
        check("ar_fresh_done", 32'(r_done), 32'd1);
        check("ar_fresh_req",  32'(n_req), 32'd1);
        check("ar_fresh_addr", r_addr, 32'h0000_8000);
        check("ar_fresh_rdata", cpu_rdata, 32'hCAFE_F00D);
        release_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
